// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-granular round-robin arbiter sharing one UART transmitter
// Optional channel-ID prefix byte per message: define UART_ARB_PREFIX_EN.
module uart_tx_arbiter #(
  parameter int         NUM_REQ = 4,
  parameter logic [7:0] ID_BASE = 8'h80
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_data_valid,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_active
);

  localparam int GW = $clog2(NUM_REQ);
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);

  // Prefix IDs must not wrap past 8'hFF, and the requester count is bounded.
  if (NUM_REQ < 2 || NUM_REQ > 8 || (int'(ID_BASE) + NUM_REQ - 1) > 255) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported NUM_REQ/ID_BASE combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_tx_data;
  logic [GW-1:0] r_grant_id;
  logic [GW-1:0] r_rr_ptr;
  logic          r_grant_active;
  logic          r_last_flag;

  logic          w_hit;
  logic [GW-1:0] w_hit_idx;
  logic          w_sel_valid;
  logic [7:0]    w_sel_data;
  logic          w_sel_last;
  logic          w_accept;
  logic          w_load_go;

  // Rotating priority search: walk offsets high to low so the lowest offset from rr_ptr wins.
  always_comb begin
    int v_sum;
    w_hit     = 1'b0;
    w_hit_idx = '0;
    v_sum     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      v_sum = int'(r_rr_ptr) + k;
      if (v_sum >= NUM_REQ) begin
        v_sum = v_sum - NUM_REQ;
      end
      if (req_valid[v_sum]) begin
        w_hit     = 1'b1;
        w_hit_idx = v_sum[GW-1:0];
      end
    end
  end

  assign w_sel_valid = req_valid[r_grant_id];
  assign w_sel_data  = req_data[r_grant_id*8 +: 8];
  assign w_sel_last  = req_last[r_grant_id];

`ifdef UART_ARB_PREFIX_EN
  logic r_prefix_pend;
  logic w_prefix_go;
  logic [7:0] w_prefix_byte;

  assign w_prefix_byte = ID_BASE + {{(8-GW){1'b0}}, r_grant_id};
  assign w_prefix_go   = (r_state == ST_LOAD) && r_prefix_pend && !tx_busy;
  assign w_accept      = (r_state == ST_LOAD) && !r_prefix_pend && w_sel_valid && !tx_busy;
  assign w_load_go     = w_prefix_go || w_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prefix_pend <= 1'b0;
    end else if (r_state == ST_IDLE && w_hit) begin
      r_prefix_pend <= 1'b1;
    end else if (w_prefix_go) begin
      r_prefix_pend <= 1'b0;
    end
  end
`else
  assign w_accept  = (r_state == ST_LOAD) && w_sel_valid && !tx_busy;
  assign w_load_go = w_accept;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    if (w_accept) begin
      req_ready[r_grant_id] = 1'b1;
    end
    case (r_state)
      ST_IDLE:      if (w_hit) w_state_nxt = ST_LOAD;
      ST_LOAD:      if (w_load_go) w_state_nxt = ST_SEND;
      ST_SEND:      w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (tx_done) w_state_nxt = r_last_flag ? ST_IDLE : ST_LOAD;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_data      <= 8'h00;
      r_grant_id     <= '0;
      r_grant_active <= 1'b0;
      r_rr_ptr       <= '0;
      r_last_flag    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_grant_id     <= w_hit_idx;
            r_grant_active <= 1'b1;
          end
        end
        ST_LOAD: begin
`ifdef UART_ARB_PREFIX_EN
          if (w_prefix_go) begin
            r_tx_data   <= w_prefix_byte;
            r_last_flag <= 1'b0;
          end else
`endif
          if (w_accept) begin
            r_tx_data   <= w_sel_data;
            r_last_flag <= w_sel_last;
          end
        end
        ST_WAIT_DONE: begin
          if (tx_done && r_last_flag) begin
            r_rr_ptr       <= (r_grant_id == LAST_IDX) ? '0 : r_grant_id + 1'b1;
            r_grant_active <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_data       = r_tx_data;
  assign tx_data_valid = (r_state == ST_SEND);
  assign grant_id      = r_grant_id;
  assign grant_active  = r_grant_active;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ independent byte-stream requesters.
- Round-robin arbitration at message granularity: a granted requester keeps the transmitter until its last byte completes.
- Drives the transmitter's byte/valid inputs and sequences each byte off the transmitter's busy/done status.
- Sits between client logic (debug, telemetry, command responses) and the UART wrapper.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_BASE, 8'h80, base value of the channel-ID prefix byte (used only with UART_ARB_PREFIX_EN).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- req_data  input  8*NUM_REQ  byte per requester; requester i occupies bits [8i+7:8i].
- req_valid  input  NUM_REQ  requester i has a byte available.
- req_last  input  NUM_REQ  byte on requester i is the last byte of its message.
- req_ready  output  NUM_REQ  one-cycle accept strobe to requester i.
- tx_data  output  8  byte to the UART transmitter.
- tx_data_valid  output  1  one-cycle start strobe to the transmitter.
- tx_busy  input  1  transmitter is shifting a frame.
- tx_done  input  1  one-cycle pulse at the end of the stop bit.
- grant_id  output  clog2(NUM_REQ)  index of the current owner.
- grant_active  output  1  a message is in progress.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - state to IDLE;
  - tx_data=0, tx_data_valid=0, req_ready=0;
  - grant_id=0, grant_active=0;
  - round-robin pointer rr_ptr=0.
- States: IDLE, LOAD, SEND, WAIT_DONE.
- IDLE:
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ.
  - First hit g: register grant_id=g, set grant_active=1, go to LOAD.
  - No hit: stay in IDLE.
  - Grant is visible the cycle after req_valid is first sampled.
- LOAD:
  - Accept condition: req_valid[g]=1 and tx_busy=0.
  - When met: req_ready[g]=1 combinationally for exactly this cycle; tx_data<=req_data[g]; latch last_flag<=req_last[g]; go to SEND.
  - Otherwise: hold in LOAD. The grant is kept indefinitely; no timeout.
- SEND: tx_data_valid=1 for exactly one cycle, with tx_data stable; go to WAIT_DONE.
- WAIT_DONE:
  - Wait for tx_done=1.
  - If last_flag=1: rr_ptr<=(g+1) mod NUM_REQ, grant_active<=0, go to IDLE.
  - Else: go to LOAD.
- req_ready is never asserted for a non-granted requester; at most one bit is set at any time.
- Minimum byte-to-byte gap: one LOAD cycle plus one SEND cycle after tx_done.
- tx_done outside WAIT_DONE is ignored.
- A requester that drops req_valid mid-message stalls the arbiter in LOAD until it returns.
- Reset mid-message:
  - The arbiter returns to IDLE and any UART frame in flight completes on its own.
  - The LOAD tx_busy guard blocks a new strobe until that frame ends.
- Simultaneous requests: the lowest index at or after rr_ptr wins. rr_ptr only advances on message completion.

Optional Feature:
- Macro: UART_ARB_PREFIX_EN.
- Enabled:
  - On entry to LOAD for the first byte of a message, the arbiter first sends one byte ID_BASE+grant_id through SEND/WAIT_DONE, with req_ready held 0 and last_flag forced 0.
  - It then proceeds with the requester's bytes.
  - Every message on the wire is therefore 1 byte longer.
- Disabled: no prefix byte; the prefix logic is absent from the RTL.

Test Plan:
- Single requester, NUM_REQ=4: req1 sends 3 bytes 8'h11, 8'h22, 8'h33 with last on 8'h33 -> tx_data_valid pulses 3 times with those bytes in order, each after the previous tx_done; grant_id=1 throughout; rr_ptr=2 afterwards.
- Contention: req0 and req2 both valid from reset with 2-byte messages -> req0's message completes fully, then req2's; bytes are never interleaved.
- Fairness: all four requesters continuously send 1-byte messages -> grant order is 0,1,2,3,0,1.
- Stall: req3 drops req_valid for 20 cycles mid-message -> the arbiter holds in LOAD, grant_id=3, no tx_data_valid pulse, and other requesters stay unserved.
- Reset mid-frame: assert rst while tx_busy=1, with req0 valid after reset -> the next tx_data_valid occurs only after tx_busy falls; all outputs read 0 during the reset cycle.
- UART_ARB_PREFIX_EN, ID_BASE=8'h80: req2 sends 1 byte 8'hA5 -> bytes 8'h82 then 8'hA5 are sent, and req_ready[2] pulses exactly once.
